// File: rtl/memory_arbiter_pkg.sv
// Shared types and limits for the frame-RAM port arbiter.
package memory_arbiter_pkg;

  localparam int unsigned MAX_PORTS      = 8;
  localparam int unsigned MAX_RD_LATENCY = 4;

  // Port id width, never narrower than one bit.
  function automatic int unsigned port_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned MAX_PORT_W = port_w(MAX_PORTS);

  typedef struct packed {
    logic                  valid;
    logic [MAX_PORT_W-1:0] id;
  } rtag_t;

  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/memory_arbiter_rtag.sv
// Read-tag delay line: carries {valid, port id} alongside the RAM read pipeline.
module memory_arbiter_rtag
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  rtag_t push,
  output rtag_t tail
);

  rtag_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[DEPTH-1];

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin N-port arbiter in front of a single-port frame RAM.
// Define MEMORY_ARBITER_LOCK_EN to let a port keep the grant via port_lock.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
  input  logic [NUM_PORTS-1:0]             port_lock,
  output logic [NUM_PORTS-1:0]             port_gnt,
  output logic [NUM_PORTS-1:0]             port_rvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_rdata,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_data,
  output logic                             mem_write_enable,
  input  logic [DATA_WIDTH-1:0]            mem_q
);

  localparam int unsigned PORT_W = port_w(NUM_PORTS);

  logic [PORT_W-1:0]     last_grant;
  logic [PORT_W-1:0]     gnt_id;
  logic [PORT_W-1:0]     hi_id;
  logic [PORT_W-1:0]     lo_id;
  logic                  hi_found;
  logic                  lo_found;
  logic                  gnt_valid;
  logic                  rr_update;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  rtag_t                 push_tag;
  rtag_t                 tail_tag;

`ifdef MEMORY_ARBITER_LOCK_EN
  lock_state_t       lock_state;
  lock_state_t       lock_next;
  logic [PORT_W-1:0] lock_owner;
  logic              sel_lock;
  logic              owner_req;
`else
  logic              lock_unused;
  assign lock_unused = ^port_lock;
`endif

  // Lowest requester above last_grant wins; otherwise wrap to lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_req[i]) begin
        if (PORT_W'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_id    = PORT_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = PORT_W'(i);
        end
      end
    end
  end

  // Grant outputs: round-robin winner, overridden by a held lock.
  always_comb begin
    port_gnt  = '0;
    gnt_id    = hi_found ? hi_id : lo_id;
    gnt_valid = hi_found | lo_found;
    rr_update = 1'b1;
`ifdef MEMORY_ARBITER_LOCK_EN
    owner_req = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (lock_owner == PORT_W'(i) && port_req[i]) owner_req = 1'b1;
    end
    if (lock_state == LOCK_HELD) begin
      gnt_id    = lock_owner;
      gnt_valid = owner_req;
      rr_update = 1'b0;
    end
`endif
    if (!rst_n) gnt_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_gnt[i] = gnt_valid && (gnt_id == PORT_W'(i));
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
`ifdef MEMORY_ARBITER_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_id == PORT_W'(i)) begin
        sel_addr  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = port_we[i];
`ifdef MEMORY_ARBITER_LOCK_EN
        sel_lock  = port_lock[i];
`endif
      end
    end
  end

`ifdef MEMORY_ARBITER_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state <= LOCK_FREE;
      lock_owner <= '0;
    end else begin
      lock_state <= lock_next;
      if (gnt_valid) lock_owner <= gnt_id;
    end
  end

  // Each accept either takes/keeps ownership or releases it.
  always_comb begin
    lock_next = lock_state;
    if (gnt_valid) lock_next = sel_lock ? LOCK_HELD : LOCK_FREE;
  end
`endif

  // RAM-side registers; address and data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_address      <= '0;
      mem_data         <= '0;
      mem_write_enable <= 1'b0;
      last_grant       <= PORT_W'(NUM_PORTS - 1);
    end else begin
      mem_write_enable <= 1'b0;
      if (gnt_valid) begin
        mem_address      <= sel_addr;
        mem_data         <= sel_wdata;
        mem_write_enable <= sel_we;
        if (rr_update) last_grant <= gnt_id;
      end
    end
  end

  always_comb begin
    push_tag       = '0;
    push_tag.valid = gnt_valid & ~sel_we;
    push_tag.id    = MAX_PORT_W'(gnt_id);
  end

  memory_arbiter_rtag #(
    .DEPTH (RD_LATENCY + 1)
  ) u_rtag (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_tag),
    .tail  (tail_tag)
  );

  // Route returning RAM data to the port that issued the read.
  always_comb begin
    port_rvalid = '0;
    port_rdata  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tail_tag.valid && tail_tag.id == MAX_PORT_W'(i)) begin
        port_rvalid[i]                          = 1'b1;
        port_rdata[i*DATA_WIDTH +: DATA_WIDTH]  = mem_q;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: 3-port/RD_LATENCY=3 instance plus a 1-port instance.
module tb_memory_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 48;
  localparam int unsigned RL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0]    port_req, port_we, port_lock, port_gnt, port_rvalid;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata, port_rdata;
  logic [AW-1:0]    mem_address;
  logic [DW-1:0]    mem_data, mem_q;
  logic             mem_write_enable;

  logic          s_req, s_we, s_lock, s_gnt, s_rvalid, s_mem_we;
  logic [AW-1:0] s_addr, s_mem_address;
  logic [DW-1:0] s_wdata, s_rdata, s_mem_data;
  logic [DW-1:0] s_mem_q = '0;

  always #5 clk = ~clk;

  memory_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) u_dut (
    .clk(clk), .rst_n(rst_n), .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_lock(port_lock), .port_gnt(port_gnt), .port_rvalid(port_rvalid),
    .port_rdata(port_rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_write_enable(mem_write_enable), .mem_q(mem_q));

  memory_arbiter #(.NUM_PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .port_req(s_req), .port_we(s_we), .port_addr(s_addr),
    .port_wdata(s_wdata), .port_lock(s_lock), .port_gnt(s_gnt), .port_rvalid(s_rvalid),
    .port_rdata(s_rdata), .mem_address(s_mem_address), .mem_data(s_mem_data),
    .mem_write_enable(s_mem_we), .mem_q(s_mem_q));

  // Frame RAM model: synchronous read, RL edges from registered address to mem_q.
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_address] <= mem_data;
    rd_pipe[0] <= ram[mem_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q = rd_pipe[RL-1];

  typedef struct {
    int unsigned   port;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [NP*DW-1:0] others;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  int unsigned   t_rd;
  int unsigned   p1_acc;
  logic [NP-1:0] exp_g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every returned read is matched against the oldest expected read.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && port_rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b expected none outstanding (cycle %0d)",
                 port_rvalid, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rvalid_port", 64'(port_rvalid), 64'(1) << mon_e.port);
        chk("rdata", 64'(port_rdata[mon_e.port*DW +: DW]), 64'(mon_e.data));
        chk("rvalid_cycle", 64'(cyc), 64'(mon_e.cyc));
        others = port_rdata;
        others[mon_e.port*DW +: DW] = '0;
        chk("rdata_others_zero", 64'(|others), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned p, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    port_req[p]           = req;
    port_we[p]            = we;
    port_addr[p*AW +: AW] = a;
    port_wdata[p*DW +: DW] = d;
    port_lock[p]          = lk;
  endtask

  task automatic issue_write(input int unsigned p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(p, 1'b1, 1'b1, a, d, 1'b0);
    #3;
    chk("write_gnt", 64'(port_gnt), 64'(1) << p);
    step();
    port_req[p] = 1'b0;
  endtask

  task automatic issue_read(input int unsigned p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(p, 1'b1, 1'b0, a, '0, 1'b0);
    #3;
    chk("read_gnt", 64'(port_gnt), 64'(1) << p);
    exp_q.push_back('{p, d, cyc + 1 + RL});
    step();
    port_req[p] = 1'b0;
  endtask

  initial begin
    port_req = '0; port_we = '0; port_lock = '0; port_addr = '0; port_wdata = '0;
    s_req = 1'b0; s_we = 1'b0; s_lock = 1'b0; s_addr = '0; s_wdata = '0;

    // Reset with every port requesting a write
    for (int i = 0; i < NP; i++) drive(i, 1'b1, 1'b1, AW'(i), DW'(i), 1'b0);
    repeat (2) step();
    #3;
    chk("reset_gnt", 64'(port_gnt), 64'(0));
    chk("reset_rvalid", 64'(port_rvalid), 64'(0));
    chk("reset_rdata", 64'(|port_rdata), 64'(0));
    chk("reset_mem_address", 64'(mem_address), 64'(0));
    chk("reset_mem_data", 64'(mem_data), 64'(0));
    chk("reset_mem_we", 64'(mem_write_enable), 64'(0));

    // Release: grants run 0,1,2,0 with no bubbles
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      exp_g = NP'(1) << (k % NP);
      chk("rr_gnt", 64'(port_gnt), 64'(exp_g));
      if (k > 0) begin
        chk("rr_mem_address", 64'(mem_address), 64'(k - 1));
        chk("rr_mem_we", 64'(mem_write_enable), 64'(1));
      end
      step();
    end
    port_req = '0;
    step();
    #3;
    chk("idle_gnt", 64'(port_gnt), 64'(0));
    chk("idle_mem_we", 64'(mem_write_enable), 64'(0));
    chk("idle_mem_address_hold", 64'(mem_address), 64'(0));

    // Port 1 write then read-back
    issue_write(1, AW'(10'h155), 48'h0000_00FF_FF00);
    #3;
    chk("wr_mem_we", 64'(mem_write_enable), 64'(1));
    chk("wr_mem_address", 64'(mem_address), 64'(10'h155));
    chk("wr_mem_data", 64'(mem_data), 64'(48'h0000_00FF_FF00));
    issue_read(1, AW'(10'h155), 48'h0000_00FF_FF00);

    // Interleaved reads from ports 0 and 1 on consecutive cycles
    issue_write(2, AW'(10'h010), 48'hA1A1_0000_5555);
    issue_write(2, AW'(10'h020), 48'h0B0B_FFFF_1234);
    issue_read(0, AW'(10'h010), 48'hA1A1_0000_5555);
    issue_read(1, AW'(10'h020), 48'h0B0B_FFFF_1234);
    repeat (RL + 3) step();

    // Reset while a read is in flight; arbitration restarts at port 0
    drive(0, 1'b1, 1'b0, AW'(10'h155), '0, 1'b0);
    #3;
    chk("flight_rd_gnt", 64'(port_gnt), 64'(1));
    t_rd = cyc;
    step();
    port_req[0] = 1'b0;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, AW'(10'h003), DW'(3), 1'b0);
    drive(1, 1'b1, 1'b1, AW'(10'h004), DW'(4), 1'b0);
    #3;
    chk("in_reset_gnt", 64'(port_gnt), 64'(0));
    step();
    rst_n = 1'b1;
    #3;
    chk("post_reset_gnt", 64'(port_gnt), 64'(1));
    step();
    port_req = '0;
    while (cyc < t_rd + 1 + RL) step();
    #3;
    chk("no_rvalid_after_reset", 64'(port_rvalid), 64'(0));
    repeat (3) step();

    // Port 1 asks for a 4-accept lock while port 0 requests throughout
    p1_acc = 0;
    drive(0, 1'b1, 1'b1, AW'(10'h030), DW'(0), 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 1'b1, 1'b1, AW'(10'h040), DW'(k), p1_acc < 3);
`ifdef MEMORY_ARBITER_LOCK_EN
      exp_g = (k == 4) ? NP'(1) : NP'(2);
`else
      exp_g = (k % 2 == 0) ? NP'(2) : NP'(1);
`endif
      #3;
      chk("lock_gnt", 64'(port_gnt), 64'(exp_g));
      if (exp_g == NP'(2)) p1_acc++;
      step();
    end
    port_req = '0;
    port_lock = '0;
    step();

    // Single-port instance: 16 consecutive accepts
    for (int k = 0; k < 16; k++) begin
      s_req = 1'b1; s_we = 1'b1; s_addr = AW'(k); s_wdata = DW'(k + 100);
      #3;
      chk("single_gnt", 64'(s_gnt), 64'(1));
      if (k > 0) chk("single_mem_address", 64'(s_mem_address), 64'(k - 1));
      step();
    end
    s_req = 1'b0;
    #3;
    chk("single_last_address", 64'(s_mem_address), 64'(15));
    chk("single_last_data", 64'(s_mem_data), 64'(115));
    chk("single_last_we", 64'(s_mem_we), 64'(1));
    chk("single_no_rvalid", 64'({s_rvalid, |s_rdata}), 64'(0));

    // Drain outstanding reads, bounded
    for (int w = 0; w < 40 && exp_q.size() != 0; w++) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
